tg_write_scheduler: RTL

TG_WRITE_SCHEDULER -- requirements
Module: tg_write_scheduler

---
 rtl/tg_pkg.sv | 20 ++
 rtl/tg_rr_arbiter.sv | 26 ++
 rtl/tg_write_scheduler.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tg_pkg.sv
// Shared types and geometry defaults for the text-grid write scheduler.
// The screen-clear sweep is only built when TG_CLEAR_EN is defined.
package tg_pkg;
  localparam int SCREEN_WIDTH  = 76;
  localparam int SCREEN_HEIGHT = 44;
  localparam int CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int AW            = $clog2(CELLS);

  localparam logic [7:0] ASCII_SPACE = 8'd32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } tg_state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } tg_req_t;
endpackage

// File: rtl/tg_rr_arbiter.sv
// Two-way round-robin grant: req[0]=term, req[1]=cpu; on a tie the requester
// not granted last wins. Priority state only moves when a grant is used.
module tg_rr_arbiter
  import tg_pkg::*;
(
  input  logic       pixel_clk_in,
  input  logic       rst_in,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_cpu;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_cpu ? 2'b01 : 2'b10;
  end

  // Reset to "cpu granted last" so term wins the first tie.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) last_cpu <= 1'b1;
    else if (advance) last_cpu <= gnt[1];
  end

endmodule

// File: rtl/tg_write_scheduler.sv
// Merges terminal and cpu writes onto one text-grid RAM port, with an optional
// full-screen clear sweep built only when TG_CLEAR_EN is defined.
module tg_write_scheduler
  import tg_pkg::*;
#(
  parameter int  SCREEN_WIDTH  = tg_pkg::SCREEN_WIDTH,
  parameter int  SCREEN_HEIGHT = tg_pkg::SCREEN_HEIGHT,
  localparam int CELLS         = SCREEN_WIDTH * SCREEN_HEIGHT,
  localparam int AW            = $clog2(CELLS)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          term_valid,
  input  logic [AW-1:0] term_addr,
  input  logic [7:0]    term_data,
  output logic          term_ready,
  input  logic          cpu_valid,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic          cpu_ready,
  input  logic          clear_req,
  output logic          clear_busy,
  output logic          tg_we,
  output logic [AW-1:0] tg_addr,
  output logic [7:0]    tg_input,
  output logic          oob_pulse
);

  localparam logic [AW:0]   CELLS_EXT = (AW+1)'(CELLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

  logic          in_clear;
  logic          start_clear;
  logic          sweep_we;
  logic [AW-1:0] sweep_addr;
  logic          blocked;
  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          xfer;
  logic          in_range;
  logic [AW-1:0] x_addr;
  logic [7:0]    x_data;

`ifdef TG_CLEAR_EN
  tg_state_t     state;
  logic [AW-1:0] sweep_cnt;
  logic          sweep_last;

  // sweep_cnt always equals the address currently presented on tg_addr.
  assign in_clear    = (state == CLEAR);
  assign start_clear = clear_req & ~in_clear;
  assign sweep_last  = (sweep_cnt == LAST_ADDR);
  assign sweep_we    = start_clear | (in_clear & ~sweep_last);
  assign sweep_addr  = in_clear ? (sweep_cnt + AW'(1)) : '0;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            sweep_cnt  <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (sweep_last) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_clear_req;

  assign unused_clear_req = clear_req;
  assign in_clear         = 1'b0;
  assign start_clear      = 1'b0;
  assign sweep_we         = 1'b0;
  assign sweep_addr       = '0;
  assign clear_busy       = 1'b0;
`endif

  // A pending clear request outranks both requesters in the same cycle.
  assign blocked = rst_in | in_clear | start_clear;
  assign req     = blocked ? 2'b00 : {cpu_valid, term_valid};

  tg_rr_arbiter u_arb (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .req          (req),
    .advance      (xfer),
    .gnt          (gnt)
  );

  assign term_ready = gnt[0];
  assign cpu_ready  = gnt[1];
  assign xfer       = |gnt;
  assign x_addr     = gnt[0] ? term_addr : cpu_addr;
  assign x_data     = gnt[0] ? term_data : cpu_data;
  assign in_range   = ({1'b0, x_addr} < CELLS_EXT);

  // Registered RAM write port; sweep writes and transfers never coincide.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      tg_we     <= 1'b0;
      tg_addr   <= '0;
      tg_input  <= '0;
      oob_pulse <= 1'b0;
    end else begin
      tg_we     <= sweep_we | (xfer & in_range);
      oob_pulse <= xfer & ~in_range;
      if (sweep_we) begin
        tg_addr  <= sweep_addr;
        tg_input <= ASCII_SPACE;
      end else if (xfer && in_range) begin
        tg_addr  <= x_addr;
        tg_input <= x_data;
      end
    end
  end

endmodule
